// File: rtl/reversible_12bit_unadder.sv
// Bit-serial inverse of the 3-operand adder: A = S - B - C, LSB first.
// Define UNADDER_RADIX4_EN to retire two bits per cycle.
module reversible_12bit_unadder #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic [1:0]       borrow,
  output logic             underflow
);

`ifdef UNADDER_RADIX4_EN
  localparam int STEPS = WIDTH / 2;
  localparam int SH    = 2;
`else
  localparam int STEPS = WIDTH;
  localparam int SH    = 1;
`endif
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] c_r;
  logic [WIDTH-1:0] a_r;
  logic [1:0]      brw;
  logic [WIDTH-1:0] a_n;
  logic [1:0]      brw_n;
  logic [2:0]      st0;
  logic [2:0]      st1;

  // d = s - b - c - brw; a = d mod 2; brw' = (a - d) / 2, kept non-negative
  function automatic logic [2:0] bit_step(
    input logic       s,
    input logic       b,
    input logic       c,
    input logic [1:0] bi
  );
    logic [2:0] t;
    logic       a;
    logic [2:0] u;
    t = 3'(b) + 3'(c) + 3'(bi);
    a = s ^ t[0];
    u = (t + 3'(a) - 3'(s)) >> 1;
    return {u[1:0], a};
  endfunction

  always_comb begin
    st0   = bit_step(s_r[0], b_r[0], c_r[0], brw);
    st1   = 3'b0;
    brw_n = st0[2:1];
    a_n   = {st0[0], a_r[WIDTH-1:1]};
`ifdef UNADDER_RADIX4_EN
    st1   = bit_step(s_r[1], b_r[1], c_r[1], st0[2:1]);
    brw_n = st1[2:1];
    a_n   = {st1[0], st0[0], a_r[WIDTH-1:2]};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      A         <= '0;
      borrow    <= 2'd0;
      underflow <= 1'b0;
      cnt       <= '0;
      brw       <= 2'd0;
      s_r       <= '0;
      b_r       <= '0;
      c_r       <= '0;
      a_r       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            s_r      <= S;
            b_r      <= B;
            c_r      <= C;
            a_r      <= '0;
            brw      <= 2'd0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          s_r <= s_r >> SH;
          b_r <= b_r >> SH;
          c_r <= c_r >> SH;
          a_r <= a_n;
          brw <= brw_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            A         <= a_n;
            borrow    <= brw_n;
            underflow <= |brw_n;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reversible_12bit_unadder.sv
// Directed bench for reversible_12bit_unadder with a result scoreboard.
// Honours UNADDER_RADIX4_EN for the expected latency.
module tb_reversible_12bit_unadder;

  localparam int W = 12;
`ifdef UNADDER_RADIX4_EN
  localparam int LAT = W / 2;
`else
  localparam int LAT = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] S;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] A;
  logic [1:0]   borrow;
  logic         underflow;

  int n_chk  = 0;
  int n_fail = 0;
  logic [13:0] sb[$];

  reversible_12bit_unadder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .S(S),
    .B(B),
    .C(C),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .A(A),
    .borrow(borrow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(logic [W-1:0] s, logic [W-1:0] b,
                          logic [W-1:0] c);
    int full;
    int a;
    int br;
    full = int'(s) - int'(b) - int'(c);
    a    = full & ((1 << W) - 1);
    br   = (a - full) >>> W;
    sb.push_back({2'(br), 12'(a)});
  endtask

  task automatic accept(logic [W-1:0] s, logic [W-1:0] b,
                        logic [W-1:0] c);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    S = s; B = b; C = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic check_result(string tag);
    logic [13:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_A"}, 32'(A), 32'(e[11:0]));
      chk({tag, "_borrow"}, 32'(borrow), 32'(e[13:12]));
      chk({tag, "_uflow"}, 32'(underflow), 32'(|e[13:12]));
    end
  endtask

  task automatic handshake(string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, 32'(out_valid), 32'd0);
    chk({tag, "_ir_high"}, 32'(in_ready), 32'd1);
  endtask

  task automatic txn(string tag, logic [W-1:0] s, logic [W-1:0] b,
                     logic [W-1:0] c, bit do_lat);
    int lat;
    push_exp(s, b, c);
    accept(s, b, c);
    wait_out(lat);
    if (do_lat) chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    check_result(tag);
    handshake(tag);
  endtask

  initial begin
    int lat;
    logic [W-1:0] a_hold;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    S = '0; B = '0; C = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_A", 32'(A), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_uflow", 32'(underflow), 32'd0);

    txn("basic", 12'h123, 12'h011, 12'h002, 1'b1);
    txn("b1", 12'h000, 12'h001, 12'h000, 1'b1);
    txn("b2", 12'h000, 12'hFFF, 12'hFFF, 1'b1);
    txn("round", 12'hA58, 12'h3C3, 12'h0F0, 1'b0);
    txn("mix", 12'h7FF, 12'h800, 12'h9AB, 1'b0);

    // backpressure: result must hold while out_ready stays low
    push_exp(12'h456, 12'h123, 12'h111);
    accept(12'h456, 12'h123, 12'h111);
    wait_out(lat);
    check_result("bp");
    a_hold = A;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        S = 12'hFFF; B = 12'h001; C = 12'h001;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_ov_hold", 32'(out_valid), 32'd1);
      chk("bp_A_hold", 32'(A), 32'(a_hold));
      chk("bp_ir_low", 32'(in_ready), 32'd0);
    end
    handshake("bp");
    repeat (W + 3) @(posedge clk);
    #1;
    chk("bp_no_ghost", 32'(out_valid), 32'd0);
    chk("bp_idle_ir", 32'(in_ready), 32'd1);

    // reset after five processed bits discards the run
    accept(12'h555, 12'h001, 12'h001);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_A", 32'(A), 32'd0);
    chk("mrst_borrow", 32'(borrow), 32'd0);
    txn("post_rst", 12'h010, 12'h008, 12'h004, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reversible_12bit_unadder.md
# reversible_12bit_unadder

Sequential inverse of the three-operand reversible 12-bit adder in the MAC8 datapath. Given a 12-bit total S and two known operands B and C, it recovers A = (S − B − C) mod 2^WIDTH bit-serially, LSB first. It also reports the final borrow, so software or test logic can undo an accumulate step or check a MAC result. It sits beside the accumulator and uses a valid/ready handshake on both sides.

## Interface
- WIDTH, 12, operand/result width; must be even when UNADDER_RADIX4_EN is defined
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  input  1  S/B/C present
- in_ready  output  1  block can accept an operand set (high only in IDLE)
- S  input  WIDTH  total (minuend)
- B  input  WIDTH  first subtrahend
- C  input  WIDTH  second subtrahend
- out_valid  output  1  A/borrow/underflow valid
- out_ready  input  1  consumer accepts the result
- A  output  WIDTH  recovered operand, (S − B − C) mod 2^WIDTH
- borrow  output  2  final borrow count, 0..2; S − B − C = A − borrow·2^WIDTH
- underflow  output  1  borrow != 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load S/B/C into shift registers, clear the borrow register, set cnt=0, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle, per bit i: d = s_i − b_i − c_i − brw.
  - a_i = d mod 2; brw_next = (a_i − d)/2.
  - brw is always in 0..2 (d ranges −4..1), held in a 2-bit register.
  - a_i shifts into the A register from the MSB end; operand registers shift right.
  - After the bit with cnt==WIDTH−1: go to DONE, set out_valid=1, latch borrow.
- DONE:
  - A, borrow and underflow are held stable while out_valid=1.
  - On out_valid & out_ready: out_valid=0, go to IDLE; in_ready=1 on the next cycle.
  - There is no same-cycle accept of a new operand set.
- A, borrow and underflow keep their last values after leaving DONE until the next result overwrites them.
- Reset (any state, including mid-RUN): next state is IDLE. The partial result is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, A=0, borrow=0, underflow=0, cnt=0, state IDLE.
- Latency: accept at edge k → out_valid high after edge k+WIDTH (12 cycles). Radix-4 build: k+WIDTH/2 (6 cycles).
- Throughput: one result per WIDTH+2 cycles with out_ready held high (accept, RUN, DONE handshake, IDLE).
- Handshake rules:
  - Data transfers only when valid & ready are both high on the same edge.
  - Once out_valid is asserted it stays asserted until the result is accepted.
  - The consumer may hold out_ready high permanently.
- in_ready is registered, not combinational from in_valid.
- rst_n low overrides every other input on that edge.

## Configuration
- UNADDER_RADIX4_EN defined:
  - Two bit positions processed per cycle, each with the same borrow rule chained combinationally within the cycle.
  - cnt steps 0..WIDTH/2−1; latency WIDTH/2.
- Not defined: one bit per cycle, latency WIDTH.
- Results, borrow, handshake and reset behaviour are identical in both builds.

## Test plan
- S=0x123, B=0x011, C=0x002 → A=0x110, borrow=0, underflow=0; out_valid exactly 12 cycles after accept (6 with UNADDER_RADIX4_EN).
- S=0x000, B=0x001, C=0x000 → A=0xFFF, borrow=1, underflow=1.
- S=0x000, B=0xFFF, C=0xFFF → A=0x002, borrow=2, underflow=1.
- Round trip: S=0xA58 (adder output for 0x5A5+0x3C3+0x0F0), B=0x3C3, C=0x0F0 → A=0x5A5, borrow=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - A, borrow and out_valid stay stable; in_ready=0.
  - A pulsed in_valid with new data is not accepted.
  - Raising out_ready → out_valid=0 the next cycle and in_ready=1.
- Reset mid-RUN: drive rst_n=0 for one edge after 5 processed bits → next cycle in_ready=1, out_valid=0, A=0, borrow=0. A following S=0x010, B=0x008, C=0x004 returns A=0x004.
